// File: rtl/dmem_arbiter_if.sv
// Bundle of the three buses around the shared data-memory port: core side,
// debug/loader side and the dmem side. The arbiter takes the slave view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // Handshakes: cpu_req is qualified by ~cpu_stall (the access happens in any
  // cycle with cpu_req=1 and cpu_stall=0); dbg_req is held until a cycle with
  // dbg_gnt=1, which is the cycle the debug access is performed; dbg_rvalid
  // marks dbg_rd for exactly one cycle after a debug read grant.
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wd;
  logic [DATA_W-1:0] cpu_rd;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_lock;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wd;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rd;
  logic              dbg_rvalid;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd,
    output cpu_rd, cpu_stall,
    input  dbg_req, dbg_lock, dbg_we, dbg_addr, dbg_wd,
    output dbg_gnt, dbg_rd, dbg_rvalid,
    output mem_we, mem_addr, mem_wd,
    input  mem_rd
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd,
    input  cpu_rd, cpu_stall,
    output dbg_req, dbg_lock, dbg_we, dbg_addr, dbg_wd,
    input  dbg_gnt, dbg_rd, dbg_rvalid,
    input  mem_we, mem_addr, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single dmem port between the MIPS core and a debug/loader port.
// CPU has priority; a starvation counter and locked bursts guarantee debug progress.
module dmem_arbiter #(
  parameter int MAX_DBG_WAIT = 4,
  parameter int BURST_MAX    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  dmem_arbiter_if.slave        bus,
  output logic [1:0]           fsm_state
);
  localparam int WAIT_W = $clog2(MAX_DBG_WAIT + 1);
  localparam int BEAT_W = $clog2(BURST_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_DBG_WAIT);
  localparam logic [BEAT_W-1:0] BEAT_CAP = BEAT_W'(BURST_MAX);

  typedef enum logic [1:0] {
    CPU_PRI   = 2'd0,
    DBG_BURST = 2'd1,
    CPU_HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              dbg_win;
  logic              dbg_read;

  always_comb begin
    dbg_win = 1'b0;
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = '0;

    unique case (state_q)
      CPU_PRI:   dbg_win = bus.dbg_req & (~bus.cpu_req | (wait_q == WAIT_SAT));
      DBG_BURST: dbg_win = bus.dbg_req;
      default:   dbg_win = 1'b0;
    endcase
    if (reset) dbg_win = 1'b0;

    // Starvation count only grows while debug is asking and losing.
    if (bus.dbg_req & ~dbg_win)
      wait_d = (wait_q == WAIT_SAT) ? wait_q : wait_q + 1'b1;

    unique case (state_q)
      CPU_PRI: begin
        if (dbg_win & bus.dbg_lock) begin
          beat_d  = BEAT_W'(1);
          state_d = (BURST_MAX == 1) ? CPU_HOLD : DBG_BURST;
        end
      end
      DBG_BURST: begin
        if (dbg_win) beat_d = beat_q + 1'b1;
        // An unlocked final beat is still granted above before leaving.
        if (~bus.dbg_req | ~bus.dbg_lock | (beat_d == BEAT_CAP))
          state_d = CPU_HOLD;
      end
      default: begin
        state_d = CPU_PRI;
        beat_d  = '0;
      end
    endcase
  end

  assign dbg_read      = dbg_win & ~bus.dbg_we;
  assign bus.dbg_gnt   = dbg_win;
  assign bus.cpu_stall = bus.cpu_req & dbg_win;
  assign bus.mem_we    = ~reset & (dbg_win ? bus.dbg_we : (bus.cpu_we & bus.cpu_req));
  assign bus.mem_addr  = dbg_win ? bus.dbg_addr : bus.cpu_addr;
  assign bus.mem_wd    = dbg_win ? bus.dbg_wd   : bus.cpu_wd;
  assign bus.cpu_rd    = bus.mem_rd;
  assign fsm_state     = state_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= CPU_PRI;
      wait_q         <= '0;
      beat_q         <= '0;
      bus.dbg_rd     <= '0;
      bus.dbg_rvalid <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      beat_q         <= beat_d;
      bus.dbg_rvalid <= dbg_read;
      if (dbg_read) bus.dbg_rd <= bus.mem_rd;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a cycle model predicts grant, stall, memory
// traffic and debug read data; directed sections pin hand-computed values.
module tb_dmem_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int MAX_W  = 4;
  localparam int BMAX   = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic       clock = 1'b0;
  logic       reset;
  logic       clr_mem;
  logic [1:0] fsm_state;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(.MAX_DBG_WAIT(MAX_W), .BURST_MAX(BMAX)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / memory ----------------
  always #5 clock = ~clock;

  logic [DATA_W-1:0] dmem [0:DEPTH-1];
  assign bus.mem_rd = dmem[bus.mem_addr];

  always @(posedge clock) begin
    if (clr_mem) begin
      for (int i = 0; i < DEPTH; i++) dmem[i] <= '0;
    end else if (bus.mem_we) begin
      dmem[bus.mem_addr] <= bus.mem_wd;
    end
  end

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  logic [DATA_W-1:0] exp_q[$];
  int m_lost;
  int m_beats;
  bit m_hold;
  bit m_rv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Debug gets the port when asking, unless the CPU holds it: CPU asks and
  // debug has not yet lost MAX_W cycles, or this is the post-burst CPU cycle.
  function automatic bit model_dbg_ok();
    if (reset || !bus.dbg_req || m_hold) return 1'b0;
    if (m_beats > 0) return 1'b1;
    return !bus.cpu_req || (m_lost >= MAX_W);
  endfunction

  task automatic model_compare();
    bit ok;
    bit we_e;
    ok   = model_dbg_ok();
    we_e = !reset && (ok ? bus.dbg_we : (bus.cpu_req && bus.cpu_we));
    check("gnt", bus.dbg_gnt, ok);
    check("stall", bus.cpu_stall, !reset && bus.cpu_req && ok);
    check("mem_we", bus.mem_we, we_e);
    if (we_e) begin
      check("mem_addr", bus.mem_addr, ok ? bus.dbg_addr : bus.cpu_addr);
      check("mem_wd", bus.mem_wd, ok ? bus.dbg_wd : bus.cpu_wd);
    end
    check("rvalid", bus.dbg_rvalid, m_rv);
    if (m_rv && exp_q.size() > 0) check("dbg_rd", bus.dbg_rd, exp_q.pop_front());
    if (!reset && bus.cpu_req && !ok && !bus.cpu_we)
      check("cpu_rd", bus.cpu_rd, ref_mem[bus.cpu_addr]);
  endtask

  task automatic model_update();
    bit ok;
    ok = model_dbg_ok();
    if (reset) begin
      m_lost = 0; m_beats = 0; m_hold = 0; m_rv = 0;
      exp_q.delete();
      return;
    end
    if (ok && bus.dbg_we) ref_mem[bus.dbg_addr] = bus.dbg_wd;
    else if (!ok && bus.cpu_req && bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_wd;
    m_rv = ok && !bus.dbg_we;
    if (m_rv) exp_q.push_back(ref_mem[bus.dbg_addr]);
    if (bus.dbg_req && !ok) begin
      if (m_lost < MAX_W) m_lost++;
    end else begin
      m_lost = 0;
    end
    if (m_hold) begin
      m_hold = 0;
    end else if (m_beats > 0) begin
      if (ok) m_beats++;
      if (!bus.dbg_req || !bus.dbg_lock || m_beats == BMAX) begin
        m_beats = 0;
        m_hold  = 1;
      end
    end else if (ok && bus.dbg_lock) begin
      m_beats = 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cpu(input bit req, input bit we, input int addr, input logic [31:0] wd);
    bus.cpu_req  = req;
    bus.cpu_we   = we;
    bus.cpu_addr = ADDR_W'(addr);
    bus.cpu_wd   = wd;
  endtask

  task automatic dbg(input bit req, input bit lock, input bit we, input int addr, input logic [31:0] wd);
    bus.dbg_req  = req;
    bus.dbg_lock = lock;
    bus.dbg_we   = we;
    bus.dbg_addr = ADDR_W'(addr);
    bus.dbg_wd   = wd;
  endtask

  task automatic cyc_check();
    @(negedge clock);
    model_compare();
  endtask

  task automatic cyc_end();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic cycle();
    cyc_check();
    cyc_end();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int run;
    int run_max;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    m_lost = 0; m_beats = 0; m_hold = 0; m_rv = 0;
    reset = 1'b1;
    clr_mem = 1'b1;
    cpu(0, 0, 0, 0);
    dbg(0, 0, 0, 0, 0);
    cycle();
    dbg(1, 0, 1, 9, 32'h55);
    cpu(1, 1, 9, 32'h66);
    cycle();
    reset = 1'b0;
    clr_mem = 1'b0;
    cpu(0, 0, 0, 0);
    dbg(0, 0, 0, 0, 0);

    cyc_check();
    check("rst_rvalid", bus.dbg_rvalid, 0);
    check("rst_dbg_rd", bus.dbg_rd, 0);
    check("rst_state", fsm_state, 0);
    cyc_end();

    // 1: CPU store then load of addr 5
    cpu(1, 1, 5, 32'hDEAD);
    cyc_check();
    check("t1_mem_we", bus.mem_we, 1);
    check("t1_stall", bus.cpu_stall, 0);
    cyc_end();
    cpu(1, 0, 5, 0);
    cyc_check();
    check("t1_cpu_rd", bus.cpu_rd, 32'hDEAD);
    cyc_end();
    cpu(0, 0, 0, 0);

    // 2: debug read with idle CPU
    dbg(1, 0, 0, 5, 0);
    cyc_check();
    check("t2_gnt", bus.dbg_gnt, 1);
    cyc_end();
    dbg(0, 0, 0, 0, 0);
    cyc_check();
    check("t2_rvalid", bus.dbg_rvalid, 1);
    check("t2_dbg_rd", bus.dbg_rd, 32'hDEAD);
    cyc_end();

    // 3: starvation, debug forced through on the 5th cycle
    cpu(1, 0, 3, 0);
    dbg(1, 0, 0, 5, 0);
    for (int i = 0; i < 6; i++) begin
      cyc_check();
      check($sformatf("t3_gnt%0d", i), bus.dbg_gnt, (i == 4));
      if (i == 4) check("t3_stall", bus.cpu_stall, 1);
      cyc_end();
    end
    cpu(0, 0, 0, 0);
    dbg(0, 0, 0, 0, 0);
    cycle();

    // 4: locked burst of writes capped at BMAX beats
    run = 0;
    run_max = 0;
    cpu(1, 0, 3, 0);
    for (int i = 0; i < 14; i++) begin
      if (i == 13) bus.cpu_req = 1'b0;
      dbg(1, 1, 1, 16 + i, 32'(i * 32'h111));
      cyc_check();
      check($sformatf("t4_gnt%0d", i), bus.dbg_gnt, ((i >= 4 && i <= 11) || i == 13));
      if (i == 12) begin
        check("t4_hold_state", fsm_state, 2);
        check("t4_hold_stall", bus.cpu_stall, 0);
      end
      if (bus.dbg_gnt) run++;
      else run = 0;
      if (run > run_max) run_max = run;
      cyc_end();
    end
    check("t4_run_max", run_max, BMAX);
    cpu(0, 0, 0, 0);
    dbg(0, 0, 0, 0, 0);
    cycle();
    cycle();
    for (int k = 0; k < 2; k++) begin
      dbg(1, 0, 0, (k == 0) ? 20 : 27, 0);
      cycle();
      dbg(0, 0, 0, 0, 0);
      cyc_check();
      check($sformatf("t4_readback%0d", k), bus.dbg_rd, (k == 0) ? 32'h444 : 32'hBBB);
      cyc_end();
    end

    // 5: reset in the middle of a locked read burst
    dbg(1, 1, 0, 5, 0);
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cpu(1, 0, 3, 0);
    cyc_check();
    check("t5_gnt", bus.dbg_gnt, 0);
    check("t5_rvalid", bus.dbg_rvalid, 0);
    check("t5_stall", bus.cpu_stall, 0);
    check("t5_state", fsm_state, 0);
    cyc_end();
    cpu(0, 0, 0, 0);
    dbg(0, 0, 0, 0, 0);
    cycle();

    // 6: same-address write race, CPU first then debug
    cpu(1, 1, 7, 1);
    dbg(1, 0, 1, 7, 2);
    cyc_check();
    check("t6_gnt_lose", bus.dbg_gnt, 0);
    cyc_end();
    check("t6_mem_cpu", dmem[7], 1);
    cpu(0, 0, 0, 0);
    cyc_check();
    check("t6_gnt_win", bus.dbg_gnt, 1);
    cyc_end();
    check("t6_mem_dbg", dmem[7], 2);
    dbg(0, 0, 0, 0, 0);
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
